// File: rtl/memgame_pkg.sv
// Shared definitions for the memory-card game: FSM encoding, LFSR taps and helpers.
package memgame_pkg;

    localparam logic [15:0] LfsrTaps = 16'hB400;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StInit       = 3'd1,
        StShuffle    = 3'd2,
        StWaitFirst  = 3'd3,
        StWaitSecond = 3'd4,
        StCompare    = 3'd5,
        StShow       = 3'd6,
        StDone       = 3'd7
    } state_e;

    // Ceiling log2, used to size slot indices from the card count.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned k = 1; k < n; k = k << 1) begin
            r++;
        end
        return r;
    endfunction

    // Card ids 2k and 2k+1 form a pair.
    function automatic logic pair_match(input int unsigned id_a, input int unsigned id_b);
        return (id_a >> 1) == (id_b >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; loaded with a non-zero seed on reset.
module lfsr16 import memgame_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;

    // Shift right, folding the dropped bit back in through the tap mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/card_board_ctrl.sv
// Memory-card game board: runtime Fisher-Yates shuffle plus flip/compare/hide FSM.
module card_board_ctrl import memgame_pkg::*; #(
    parameter int unsigned NUM_CARDS   = 16,
    parameter int unsigned IDX_W       = clog2(NUM_CARDS),
    parameter int unsigned HIDE_CYCLES = 25000000,
    parameter int unsigned CNT_W       = 25,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       sel_valid,
    input  logic [IDX_W-1:0]           sel_idx,
    output logic                       sel_ready,
    output logic                       sel_err,
    output logic [NUM_CARDS*IDX_W-1:0] pos_flat,
    output logic [NUM_CARDS-1:0]       revealed,
    output logic [NUM_CARDS-1:0]       matched,
    output logic                       busy,
    output logic                       game_done,
    output logic [IDX_W-1:0]           match_count,
    output logic [7:0]                 attempts
);

    logic [15:0]          lfsr;
    logic [IDX_W-1:0]     shuf_j;
    logic                 unused_lfsr;
    logic                 sel_ok;

    state_e               state_q;
    logic [IDX_W-1:0]     pos_q [NUM_CARDS];
    logic [IDX_W-1:0]     shuf_i_q;
    logic [IDX_W-1:0]     sel_a_q;
    logic [IDX_W-1:0]     sel_b_q;
    logic [NUM_CARDS-1:0] revealed_q;
    logic [NUM_CARDS-1:0] matched_q;
    logic [IDX_W-1:0]     match_count_q;
    logic [7:0]           attempts_q;
    logic [CNT_W-1:0]     hide_cnt_q;
    logic                 sel_ready_q;
    logic                 sel_err_q;
    logic                 busy_q;
    logic                 game_done_q;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .out  (lfsr)
    );

    assign shuf_j      = lfsr[IDX_W-1:0];
    assign unused_lfsr = ^lfsr[15:IDX_W];
    // sel_ready_q is high exactly in the two wait states.
    assign sel_ok      = sel_ready_q && !matched_q[sel_idx] && !revealed_q[sel_idx];

    // Game FSM; flag outputs are updated on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            for (int k = 0; k < NUM_CARDS; k++) pos_q[k] <= IDX_W'(k);
            shuf_i_q      <= '0;
            sel_a_q       <= '0;
            sel_b_q       <= '0;
            revealed_q    <= '0;
            matched_q     <= '0;
            match_count_q <= '0;
            attempts_q    <= '0;
            hide_cnt_q    <= '0;
            sel_ready_q   <= 1'b0;
            sel_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            game_done_q   <= 1'b0;
        end else begin
            sel_err_q <= 1'b0;
            if (start) begin
                state_q       <= StInit;
                revealed_q    <= '0;
                matched_q     <= '0;
                match_count_q <= '0;
                attempts_q    <= '0;
                hide_cnt_q    <= '0;
                sel_ready_q   <= 1'b0;
                busy_q        <= 1'b1;
                game_done_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: ;
                    StInit: begin
                        for (int k = 0; k < NUM_CARDS; k++) pos_q[k] <= IDX_W'(k);
                        shuf_i_q <= IDX_W'(NUM_CARDS - 1);
                        state_q  <= StShuffle;
                    end
                    StShuffle: begin
                        // Out-of-range draws are simply retried on the next LFSR value.
                        if (shuf_j <= shuf_i_q) begin
                            pos_q[shuf_i_q] <= pos_q[shuf_j];
                            pos_q[shuf_j]   <= pos_q[shuf_i_q];
                            shuf_i_q        <= shuf_i_q - 1'b1;
                            if (shuf_i_q == IDX_W'(1)) begin
                                state_q     <= StWaitFirst;
                                busy_q      <= 1'b0;
                                sel_ready_q <= 1'b1;
                            end
                        end
                    end
                    StWaitFirst: begin
                        if (sel_valid) begin
                            if (sel_ok) begin
                                revealed_q[sel_idx] <= 1'b1;
                                sel_a_q             <= sel_idx;
                                state_q             <= StWaitSecond;
                            end else begin
                                sel_err_q <= 1'b1;
                            end
                        end
                    end
                    StWaitSecond: begin
                        if (sel_valid) begin
                            if (sel_ok) begin
                                revealed_q[sel_idx] <= 1'b1;
                                sel_b_q             <= sel_idx;
                                state_q             <= StCompare;
                                sel_ready_q         <= 1'b0;
                            end else begin
                                sel_err_q <= 1'b1;
                            end
                        end
                    end
                    StCompare: begin
                        if (attempts_q != 8'hFF) attempts_q <= attempts_q + 1'b1;
                        if (pair_match(32'(pos_q[sel_a_q]), 32'(pos_q[sel_b_q]))) begin
                            matched_q[sel_a_q] <= 1'b1;
                            matched_q[sel_b_q] <= 1'b1;
                            match_count_q      <= match_count_q + 1'b1;
                            if (match_count_q == IDX_W'(NUM_CARDS / 2 - 1)) begin
                                state_q     <= StDone;
                                game_done_q <= 1'b1;
                            end else begin
                                state_q     <= StWaitFirst;
                                sel_ready_q <= 1'b1;
                            end
                        end else begin
                            state_q    <= StShow;
                            hide_cnt_q <= '0;
                        end
                    end
                    StShow: begin
                        if (hide_cnt_q == CNT_W'(HIDE_CYCLES - 1)) begin
                            revealed_q[sel_a_q] <= 1'b0;
                            revealed_q[sel_b_q] <= 1'b0;
                            state_q             <= StWaitFirst;
                            sel_ready_q         <= 1'b1;
                        end else begin
                            hide_cnt_q <= hide_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Flatten the slot array for the draw logic.
    for (genvar g = 0; g < NUM_CARDS; g++) begin : g_flat
        assign pos_flat[g*IDX_W +: IDX_W] = pos_q[g];
    end

    assign sel_ready   = sel_ready_q;
    assign sel_err     = sel_err_q;
    assign revealed    = revealed_q;
    assign matched     = matched_q;
    assign busy        = busy_q;
    assign game_done   = game_done_q;
    assign match_count = match_count_q;
    assign attempts    = attempts_q;

endmodule
